// File: rtl/vga_sync_receiver.sv
// Receive-side VGA monitor: recovers x/y/video_on from an hsync/vsync stream,
// measures line and frame geometry, tracks lock and counts lit active pixels.
module vga_sync_receiver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk25,
    input  logic        reset_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        locked,
    output logic        frame_done,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [18:0] frame_pixels,
    output logic        err_h,
    output logic        err_v
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_LOAD    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_LOAD    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] CNT_MAX   = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  hs_pipe_reg;
    logic [1:0]  vs_pipe_reg;
    logic [2:0]  rgb_s1_reg;
    logic [2:0]  rgb_s2_reg;
    logic [9:0]  hc_reg;
    logic [9:0]  vc_reg;
    logic [9:0]  plen_reg;
    logic [9:0]  lc_reg;
    logic [18:0] acc_reg;
    logic [9:0]  line_len_reg;
    logic [9:0]  frame_lines_reg;
    logic [18:0] frame_pixels_reg;
    logic        frame_done_reg;
    logic        err_h_reg;
    logic        err_v_reg;

    logic h_fall;
    logic v_fall;
    logic h_wrap;
    logic h_bad;
    logic v_bad;

    // Bit 0 is the first stage, bit 1 the second; a fall is seen as old-high/new-low.
    assign h_fall = hs_pipe_reg[1] & ~hs_pipe_reg[0];
    assign v_fall = vs_pipe_reg[1] & ~vs_pipe_reg[0];
    assign h_wrap = !h_fall && (hc_reg == H_LAST);
    assign h_bad  = h_fall && (plen_reg != H_TOTAL_C);
    assign v_bad  = v_fall && (lc_reg != V_TOTAL_C);

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            hs_pipe_reg <= 2'b00;
            vs_pipe_reg <= 2'b00;
            rgb_s1_reg  <= 3'b000;
            rgb_s2_reg  <= 3'b000;
        end else begin
            hs_pipe_reg <= {hs_pipe_reg[0], hsync};
            vs_pipe_reg <= {vs_pipe_reg[0], vsync};
            rgb_s1_reg  <= rgb;
            rgb_s2_reg  <= rgb_s1_reg;
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            hc_reg <= '0;
            vc_reg <= '0;
        end else begin
            if (h_fall) begin
                hc_reg <= H_LOAD;
            end else if (hc_reg == H_LAST) begin
                hc_reg <= '0;
            end else begin
                hc_reg <= hc_reg + 10'd1;
            end

            if (v_fall) begin
                vc_reg <= V_LOAD;
            end else if (h_wrap) begin
                vc_reg <= (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            plen_reg         <= '0;
            line_len_reg     <= '0;
            lc_reg           <= '0;
            frame_lines_reg  <= '0;
            acc_reg          <= '0;
            frame_pixels_reg <= '0;
        end else begin
            if (h_fall) begin
                line_len_reg <= plen_reg;
                plen_reg     <= 10'd1;
            end else if (plen_reg != CNT_MAX) begin
                plen_reg <= plen_reg + 10'd1;
            end

            // Line count saturates so a missing vsync can never alias to a valid total.
            if (v_fall) begin
                frame_lines_reg <= lc_reg;
                lc_reg          <= h_fall ? 10'd1 : 10'd0;
            end else if (h_fall && (lc_reg != CNT_MAX)) begin
                lc_reg <= lc_reg + 10'd1;
            end

            if (v_fall) begin
                frame_pixels_reg <= acc_reg;
                acc_reg          <= '0;
            end else if (video_on && (rgb_s2_reg != 3'b000)) begin
                acc_reg <= acc_reg + 19'd1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state_reg      <= SEARCH;
            frame_done_reg <= 1'b0;
            err_h_reg      <= 1'b0;
            err_v_reg      <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            // A saturated line period means hsync is gone: drop lock from any state.
            if (plen_reg == CNT_MAX) begin
                state_reg <= SEARCH;
            end else begin
                case (state_reg)
                    SEARCH: begin
                        if (v_fall) begin
                            state_reg <= ALIGN;
                        end
                    end
                    ALIGN: begin
                        if (v_fall && (line_len_reg == H_TOTAL_C) && (lc_reg == V_TOTAL_C)) begin
                            state_reg <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (h_bad) begin
                            err_h_reg <= 1'b1;
                            state_reg <= ALIGN;
                        end
                        if (v_bad) begin
                            err_v_reg <= 1'b1;
                            state_reg <= ALIGN;
                        end
                        if (v_fall && !h_bad && !v_bad) begin
                            frame_done_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign x            = hc_reg;
    assign y            = vc_reg;
    assign locked       = (state_reg == LOCKED);
    assign video_on     = locked && (hc_reg < H_ACT_C) && (vc_reg < V_ACT_C);
    assign frame_done   = frame_done_reg;
    assign line_len     = line_len_reg;
    assign frame_lines  = frame_lines_reg;
    assign frame_pixels = frame_pixels_reg;
    assign err_h        = err_h_reg;
    assign err_v        = err_v_reg;

endmodule
